// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Fetch-stage program-counter generator. Holds the
//                architectural PC and picks the next PC from trap, branch,
//                jalr, hold and sequential sources. Adds a one-cycle boot
//                state, a fetch valid/ready handshake, a misaligned-target
//                check and a halt state that only a trap can leave.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int              INC       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [1:0]      pcsrc,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            trap_req,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic            misalign,
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Next-PC select encodings
    localparam logic [1:0] c_SRC_SEQ    = 2'd0;
    localparam logic [1:0] c_SRC_BRANCH = 2'd1;
    localparam logic [1:0] c_SRC_JALR   = 2'd2;

    localparam logic [XLEN-1:0] c_INC       = XLEN'(INC);
    // Masks off bit 0 of the jalr target while keeping every input bit in use
    localparam logic [XLEN-1:0] c_BIT0_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_next_pc;
    logic            r_misalign;
    logic            w_next_misalign;

    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_jalr_clr;
    logic [XLEN-1:0] w_redirect_tgt;
    logic            w_redirect;
    logic            w_tgt_misaligned;

    assign w_pc_inc   = r_pc + c_INC;
    assign w_jalr_clr = jalr_target & c_BIT0_MASK;

    // Target selection for the two checked redirect sources
    always_comb begin
        w_redirect     = 1'b0;
        w_redirect_tgt = pc_target;
        if (pcsrc == c_SRC_BRANCH) begin
            w_redirect     = 1'b1;
            w_redirect_tgt = pc_target;
        end else if (pcsrc == c_SRC_JALR) begin
            w_redirect     = 1'b1;
            w_redirect_tgt = w_jalr_clr;
        end
    end

    assign w_tgt_misaligned = (w_redirect_tgt[1:0] != 2'b00);

    // State, PC and sticky flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_misalign <= w_next_misalign;
        end
    end

    // Next-state and next-PC selection in priority order
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_misalign = r_misalign;
        case (r_state)
            ST_BOOT: begin
                // Trap requests are ignored until the first fetch is issued
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (trap_req) begin
                    // Trap wins even over a misaligned target in the same cycle
                    w_next_pc = TRAP_VEC;
                end else if (w_redirect) begin
                    if (w_tgt_misaligned) begin
                        w_next_misalign = 1'b1;
                        w_next_state    = ST_HALT;
                    end else begin
                        w_next_pc = w_redirect_tgt;
                    end
                end else if (pcsrc == c_SRC_SEQ) begin
                    // Advance only when the current request is accepted
                    if (!stall && fetch_ready) begin
                        w_next_pc = w_pc_inc;
                    end
                end
            end
            ST_HALT: begin
                if (trap_req) begin
                    w_next_pc       = TRAP_VEC;
                    w_next_misalign = 1'b0;
                    w_next_state    = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_BOOT;
                w_next_pc    = RESET_VEC;
            end
        endcase
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_inc;
    assign pc_valid = (r_state == ST_RUN);
    assign halted   = (r_state == ST_HALT);
    assign misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen: directed scenarios plus a
//                randomized run compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] pc_target;
    logic [31:0] jalr_target;
    logic        trap_req;
    logic        fetch_ready;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        misalign;
    logic        halted;

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic        w_pc_valid;
    logic        w_misalign;
    logic        w_halted;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0 = boot, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN(32), .RESET_VEC(32'h0000_0000), .TRAP_VEC(32'h0000_0100), .INC(4)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc),
        .pc_target(pc_target), .jalr_target(jalr_target),
        .trap_req(trap_req), .fetch_ready(fetch_ready),
        .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid),
        .misalign(misalign), .halted(halted)
    );

    pc_gen #(
        .XLEN(32), .RESET_VEC(32'hFFFF_FFFC), .TRAP_VEC(32'h0000_0100), .INC(4)
    ) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc),
        .pc_target(pc_target), .jalr_target(jalr_target),
        .trap_req(trap_req), .fetch_ready(fetch_ready),
        .pc(w_pc), .pc_plus4(w_pc_plus4), .pc_valid(w_pc_valid),
        .misalign(w_misalign), .halted(w_halted)
    );

    // Applies the rules to the inputs presented for the coming edge
    task automatic model_step();
        logic [31:0] t;
        if (rst) begin
            m_mode = 0; m_pc = 32'h0; m_mis = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (trap_req) begin
                m_pc = 32'h100;
            end else if (pcsrc == 2'd1 || pcsrc == 2'd2) begin
                t = (pcsrc == 2'd1) ? pc_target : jalr_target;
                if (pcsrc == 2'd2) t[0] = 1'b0;
                if ((t % 4) != 0) begin
                    m_mis = 1'b1; m_mode = 2;
                end else begin
                    m_pc = t;
                end
            end else if (pcsrc == 2'd0 && !stall && fetch_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (trap_req) begin
                m_pc = 32'h100; m_mis = 1'b0; m_mode = 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; pcsrc = 2'd3; pc_target = 32'h0; jalr_target = 32'h0;
        trap_req = 1'b0; fetch_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
        checks++; if (misalign !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: got mis=%b halt=%b want 0/0", misalign, halted); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_plus4: got %h want %h", pc_plus4, 32'h4); end
        rst = 1'b0;
        trap_req = 1'b1;   // ignored in boot
        tick();
        trap_req = 1'b0;
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL boot_valid: got %b want 1", pc_valid); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc: got %h want %h", pc, 32'h0); end
    endtask

    task automatic test_sequential();
        logic        rdy [5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp [5]  = '{32'h4, 32'h8, 32'h8, 32'h8, 32'hC};
        idle_inputs();
        pcsrc = 2'd0;
        for (int i = 0; i < 5; i++) begin
            fetch_ready = rdy[i];
            tick();
            checks++; if (pc !== exp[i]) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, exp[i]); end
            checks++; if (pc_plus4 !== exp[i] + 32'd4) begin errors++; $display("FAIL seq_plus4[%0d]: got %h want %h", i, pc_plus4, exp[i] + 32'd4); end
        end
    endtask

    task automatic test_redirect();
        idle_inputs();
        stall = 1'b1; pcsrc = 2'd1; pc_target = 32'h28;
        tick();
        checks++; if (pc !== 32'h28) begin errors++; $display("FAIL redirect_stall: got %h want %h", pc, 32'h28); end
        pc_target = 32'h40; trap_req = 1'b1;
        tick();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL redirect_trap: got %h want %h", pc, 32'h100); end
        // trap beats a misaligned target in the same cycle
        pc_target = 32'h2A;
        tick();
        checks++; if (pc !== 32'h100 || halted !== 1'b0) begin errors++; $display("FAIL trap_over_misalign: got pc=%h halt=%b want 100/0", pc, halted); end
        idle_inputs();
    endtask

    task automatic test_jalr();
        idle_inputs();
        pcsrc = 2'd2; jalr_target = 32'h105;
        tick();
        checks++; if (pc !== 32'h104 || misalign !== 1'b0) begin errors++; $display("FAIL jalr_clear: got pc=%h mis=%b want 104/0", pc, misalign); end
        jalr_target = 32'h107;
        tick();
        checks++; if (pc !== 32'h104) begin errors++; $display("FAIL jalr_mis_pc: got %h want %h", pc, 32'h104); end
        checks++; if (misalign !== 1'b1 || pc_valid !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL jalr_mis_flags: got mis=%b val=%b halt=%b want 1/0/1", misalign, pc_valid, halted); end
        idle_inputs();
        trap_req = 1'b1;
        tick();
        trap_req = 1'b0;
        checks++; if (pc !== 32'h100 || pc_valid !== 1'b1) begin errors++; $display("FAIL jalr_recover: got pc=%h val=%b want 100/1", pc, pc_valid); end
    endtask

    task automatic test_misalign_branch();
        idle_inputs();
        pcsrc = 2'd1; pc_target = 32'h40;
        tick();
        pc_target = 32'h2A;
        tick();
        checks++; if (halted !== 1'b1 || misalign !== 1'b1 || pc !== 32'h40) begin errors++; $display("FAIL br_mis: got halt=%b mis=%b pc=%h want 1/1/40", halted, misalign, pc); end
        pc_target = 32'h80; fetch_ready = 1'b1; pcsrc = 2'd1;
        tick();
        checks++; if (pc !== 32'h40 || halted !== 1'b1) begin errors++; $display("FAIL halt_ignores: got pc=%h halt=%b want 40/1", pc, halted); end
        idle_inputs();
        trap_req = 1'b1;
        tick();
        trap_req = 1'b0;
        checks++; if (pc !== 32'h100 || misalign !== 1'b0 || pc_valid !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_trap: got pc=%h mis=%b val=%b halt=%b want 100/0/1/0", pc, misalign, pc_valid, halted); end
        pcsrc = 2'd1; pc_target = 32'h2A;
        tick();
        idle_inputs();
        rst = 1'b1; trap_req = 1'b1;
        tick();
        rst = 1'b0; trap_req = 1'b0;
        checks++; if (pc !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL halt_reset: got pc=%h val=%b halt=%b mis=%b want 0/0/0/0", pc, pc_valid, halted, misalign); end
    endtask

    task automatic test_wrap();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (w_pc !== 32'hFFFF_FFFC || w_pc_valid !== 1'b1 || w_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_start: got pc=%h val=%b p4=%h want fffffffc/1/0", w_pc, w_pc_valid, w_pc_plus4); end
        pcsrc = 2'd0; fetch_ready = 1'b1;
        tick();
        checks++; if (w_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want %h", w_pc, 32'h0); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] t;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            trap_req    = ($urandom_range(0, 9) == 0);
            pcsrc       = (($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3)));
            t           = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            pc_target   = t;
            t           = $urandom;
            if ($urandom_range(0, 3) != 0) t[1] = 1'b0;
            jalr_target = t;
            tick();
            checks++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || pc_valid !== (m_mode == 1) ||
                halted !== (m_mode == 2) || misalign !== m_mis) begin
                errors++;
                $display("FAIL rand[%0d]: got pc=%h p4=%h val=%b halt=%b mis=%b want pc=%h val=%b halt=%b mis=%b",
                         i, pc, pc_plus4, pc_valid, halted, misalign,
                         m_pc, (m_mode == 1), (m_mode == 2), m_mis);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_mode = 0; m_pc = 32'h0; m_mis = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_redirect();
        test_jalr();
        test_misalign_branch();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
